// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: control codes, FSM states and the
// code-valid check used by both the arbiter and the ALU decoder.
package alu_pkg;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SOLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // 1 when the code is one the ALU implements
  function automatic logic ctrl_ok(input logic [3:0] c);
    case (c)
      CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SOLT, CTRL_NOR: ctrl_ok = 1'b1;
      default:                                                     ctrl_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational core ALU. Unsupported codes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  // Operation decode; ADD/SUB wrap, SOLT is an unsigned compare
  always_comb begin
    y_o = '0;
    if (ctrl_ok(ctrl_i)) begin
      case (ctrl_i)
        CTRL_AND:  y_o = a_i & b_i;
        CTRL_OR:   y_o = a_i | b_i;
        CTRL_ADD:  y_o = a_i + b_i;
        CTRL_SUB:  y_o = a_i - b_i;
        CTRL_SOLT: y_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
        CTRL_NOR:  y_o = ~(a_i | b_i);
        default:   y_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU. Operands are registered on accept, the
// ALU runs in EXEC, and result/zf/err are registered into RESP until the
// granted port consumes them.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int DATA_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req1_valid,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic [3:0]        i_req0_ctrl,
  input  logic [3:0]        i_req1_ctrl,
  output logic              o_rsp0_valid,
  output logic              o_rsp1_valid,
  input  logic              i_rsp0_ready,
  input  logic              i_rsp1_ready,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic              o_rsp_zf,
  output logic              o_rsp_err
);

  state_e            state_q;
  logic              gid_q;      // port being served
  logic              ptr_q;      // port favoured on the next round-robin tie
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [3:0]        ctrl_q;
  logic [DATA_W-1:0] res_q;
  logic              zf_q, err_q;
  logic              rsp0_v_q, rsp1_v_q;

  logic              gnt, accept, code_ok, rsp_fire;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;

  // Grant selection and request readies; ready is gated by reset so both
  // readies read 0 while reset is held even if a requester is valid.
  always_comb begin
    gnt = i_req1_valid;
    if (i_req0_valid && i_req1_valid)
      gnt = (PRIORITY_MODE == 1) ? 1'b0 : ptr_q;
    o_req0_ready = i_rst_n && (state_q == ST_IDLE) && i_req0_valid && !gnt;
    o_req1_ready = i_rst_n && (state_q == ST_IDLE) && i_req1_valid &&  gnt;
    accept       = o_req0_ready || o_req1_ready;
  end

  // Unsupported codes never reach the ALU: it sees AND on zero operands
  always_comb begin
    code_ok  = ctrl_ok(ctrl_q);
    alu_ctrl = code_ok ? ctrl_q : CTRL_AND;
    alu_a    = code_ok ? op1_q  : '0;
    alu_b    = code_ok ? op2_q  : '0;
    rsp_fire = gid_q ? i_rsp1_ready : i_rsp0_ready;
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .ctrl_i (alu_ctrl),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .y_o    (alu_y)
  );

  // Control FSM: accept -> execute -> hold response until consumed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      gid_q    <= 1'b0;
      ptr_q    <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= CTRL_AND;
      res_q    <= '0;
      zf_q     <= 1'b0;
      err_q    <= 1'b0;
      rsp0_v_q <= 1'b0;
      rsp1_v_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op1_q   <= gnt ? i_req1_op1  : i_req0_op1;
            op2_q   <= gnt ? i_req1_op2  : i_req0_op2;
            ctrl_q  <= gnt ? i_req1_ctrl : i_req0_ctrl;
            gid_q   <= gnt;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= alu_y;
          zf_q    <= (alu_y == '0);
          err_q   <= !code_ok;
          if (gid_q) rsp1_v_q <= 1'b1;
          else       rsp0_v_q <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp0_v_q <= 1'b0;
            rsp1_v_q <= 1'b0;
            ptr_q    <= ~gid_q;   // the other port wins the next tie
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp0_valid = rsp0_v_q;
  assign o_rsp1_valid = rsp1_v_q;
  assign o_rsp_result = res_q;
  assign o_rsp_zf     = zf_q;
  assign o_rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a
// fixed-priority instance share clock and reset.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // round-robin DUT signals
  logic        r0v, r1v, r_rr0, r_rr1;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [3:0]  r0c, r1c;
  logic        r_rdy0, r_rdy1, r_rv0, r_rv1, r_zf, r_err;
  logic [31:0] r_res;

  // fixed-priority DUT signals
  logic        f0v, f1v, f_rr0, f_rr1;
  logic [31:0] f0a, f0b, f1a, f1b;
  logic [3:0]  f0c, f1c;
  logic        f_rdy0, f_rdy1, f_rv0, f_rv1, f_zf, f_err;
  logic [31:0] f_res;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIORITY_MODE(0), .DATA_W(32)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(r0v), .i_req1_valid(r1v),
    .o_req0_ready(r_rdy0), .o_req1_ready(r_rdy1),
    .i_req0_op1(r0a), .i_req0_op2(r0b), .i_req1_op1(r1a), .i_req1_op2(r1b),
    .i_req0_ctrl(r0c), .i_req1_ctrl(r1c),
    .o_rsp0_valid(r_rv0), .o_rsp1_valid(r_rv1),
    .i_rsp0_ready(r_rr0), .i_rsp1_ready(r_rr1),
    .o_rsp_result(r_res), .o_rsp_zf(r_zf), .o_rsp_err(r_err)
  );

  alu_arbiter #(.PRIORITY_MODE(1), .DATA_W(32)) u_fx (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(f0v), .i_req1_valid(f1v),
    .o_req0_ready(f_rdy0), .o_req1_ready(f_rdy1),
    .i_req0_op1(f0a), .i_req0_op2(f0b), .i_req1_op1(f1a), .i_req1_op2(f1b),
    .i_req0_ctrl(f0c), .i_req1_ctrl(f1c),
    .o_rsp0_valid(f_rv0), .o_rsp1_valid(f_rv1),
    .i_rsp0_ready(f_rr0), .i_rsp1_ready(f_rr1),
    .o_rsp_result(f_res), .o_rsp_zf(f_zf), .o_rsp_err(f_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on the round-robin DUT with response ready held high
  task automatic rr_op(input bit port, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic zf, input logic err, input string tag);
    if (!port) begin r0v = 1; r0c = c; r0a = a; r0b = b; end
    else       begin r1v = 1; r1c = c; r1a = a; r1b = b; end
    r_rr0 = 1; r_rr1 = 1;
    #1;
    chk({tag, ":rdy_T"}, port ? r_rdy1 : r_rdy0, 1);
    step();
    r0v = 0; r1v = 0;
    #1;
    chk({tag, ":rv_T1"}, {30'd0, r_rv1, r_rv0}, 0);
    step();
    chk({tag, ":rv_T2"}, {30'd0, r_rv1, r_rv0}, port ? 2 : 1);
    chk({tag, ":res"}, r_res, res);
    chk({tag, ":zf"}, r_zf, zf);
    chk({tag, ":err"}, r_err, err);
    step();
    chk({tag, ":rv_T3"}, {30'd0, r_rv1, r_rv0}, 0);
  endtask

  initial begin
    rst_n = 0;
    {r0v, r1v, r_rr0, r_rr1, f0v, f1v, f_rr0, f_rr1} = '0;
    {r0a, r0b, r1a, r1b, f0a, f0b, f1a, f1b} = '0;
    {r0c, r1c, f0c, f1c} = '0;
    step(); step();
    chk("reset:rv", {30'd0, r_rv1, r_rv0}, 0);
    chk("reset:res", r_res, 0);
    chk("reset:zf_err", {30'd0, r_zf, r_err}, 0);
    rst_n = 1;
    step();

    // single ADD on port 0
    rr_op(0, 4'b0010, 32'd5, 32'd7, 32'd12, 0, 0, "add5_7");

    // round-robin tie on u_rr, fixed priority on u_fx, both from fresh reset
    rst_n = 0; step(); rst_n = 1;
    r0v = 1; r0c = 4'b0110; r0a = 9;    r0b = 9;
    r1v = 1; r1c = 4'b0001; r1a = 'hF0; r1b = 'h0F;
    f0v = 1; f0c = 4'b0110; f0a = 9;    f0b = 9;
    f1v = 1; f1c = 4'b0001; f1a = 'hF0; f1b = 'h0F;
    r_rr0 = 1; r_rr1 = 1; f_rr0 = 1; f_rr1 = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d:rdy", k), {30'd0, r_rdy1, r_rdy0}, (k % 2) ? 2 : 1);
      chk($sformatf("fx%0d:rdy", k), {30'd0, f_rdy1, f_rdy0}, 1);
      step();
      chk($sformatf("rr%0d:rdy_exec", k), {30'd0, r_rdy1, r_rdy0}, 0);
      step();
      chk($sformatf("rr%0d:rv", k), {30'd0, r_rv1, r_rv0}, (k % 2) ? 2 : 1);
      chk($sformatf("rr%0d:res", k), r_res, (k % 2) ? 32'hFF : 32'h0);
      chk($sformatf("rr%0d:zf", k), r_zf, (k % 2) ? 0 : 1);
      chk($sformatf("fx%0d:rv", k), {30'd0, f_rv1, f_rv0}, 1);
      chk($sformatf("fx%0d:res_zf", k), {f_res[30:0], f_zf}, 1);
      step();
    end
    r0v = 0; r1v = 0; f0v = 0; f1v = 0;

    // back-pressure on port 1
    r1v = 1; r1c = 4'b1100; r1a = 0; r1b = 0; r_rr1 = 0; r_rr0 = 0;
    #1;
    chk("bp:rdy_T", r_rdy1, 1);
    step();
    r0v = 1; r0c = 4'b0010;
    #1;
    chk("bp:rdy_exec", {30'd0, r_rdy1, r_rdy0}, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d:rv1", i), r_rv1, 1);
      chk($sformatf("bp%0d:res", i), r_res, 32'hFFFF_FFFF);
      chk($sformatf("bp%0d:rdy", i), {30'd0, r_rdy1, r_rdy0}, 0);
      r_rr0 = 1;    // other port's ready must be ignored
      step();
    end
    r_rr1 = 1; r0v = 0; r1v = 0;
    #1;
    chk("bp:rv1_before_release", r_rv1, 1);
    step();
    chk("bp:rv1_after_release", r_rv1, 0);

    // unsigned compare and unsupported code
    rr_op(0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, "solt_big");
    rr_op(0, 4'b0111, 32'd1, 32'd2, 32'd1, 0, 0, "solt_1_2");
    rr_op(1, 4'b0011, 32'd3, 32'd4, 32'd0, 1, 1, "bad_ctrl");

    // reset in the middle of EXEC
    r0v = 1; r0c = 4'b0010; r0a = 1; r0b = 2; r_rr0 = 1;
    #1;
    chk("rstx:rdy_T", r_rdy0, 1);
    step();
    rst_n = 0;
    #1;
    chk("rstx:rv", {30'd0, r_rv1, r_rv0}, 0);
    chk("rstx:zf_err", {30'd0, r_zf, r_err}, 0);
    chk("rstx:res", r_res, 0);
    chk("rstx:rdy", {30'd0, r_rdy1, r_rdy0}, 0);
    step(); step();
    chk("rstx:rv_held", {30'd0, r_rv1, r_rv0}, 0);
    r0v = 0; rst_n = 1;
    step();
    rr_op(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, "add_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
